// File: rtl/operand_entry.sv
// Operand entry front end: synchronises three raw buttons, builds one-cycle presses and runs the
// A/B entry FSM. Define DEBOUNCE_EN to insert the counter debouncer; otherwise db follows s2.
`timescale 1ns/1ps

module operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       sys_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_sw,
  input  logic       i_btn_sign,
  input  logic       i_btn_load,
  input  logic       i_btn_clr,
  output logic [4:0] o_A,
  output logic [4:0] o_B,
  output logic       o_stage_sign,
  output logic [1:0] o_state,
  output logic       o_valid,
  output logic       o_load_pulse
);

  localparam int unsigned NumBtn  = 3;
  localparam int unsigned BtnSign = 0;
  localparam int unsigned BtnLoad = 1;
  localparam int unsigned BtnClr  = 2;

  // {sign, magnitude}; sign 1 means positive, so this is +0
  localparam logic [4:0] PosZero = 5'b1_0000;

  typedef enum logic [1:0] {
    StEnterA  = 2'd0,
    StEnterB  = 2'd1,
    StReady   = 2'd2,
    StInvalid = 2'd3
  } state_e;

  if (DEBOUNCE_CYCLES == 0) begin : g_bad_param
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  // --------------------------------------------------------------------------
  // Button input path: synchroniser, optional debouncer, rising-edge detect
  // --------------------------------------------------------------------------
  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] sync1_q;
  logic [NumBtn-1:0] sync2_q;
  logic [NumBtn-1:0] db;
  logic [NumBtn-1:0] db_dly_q;
  logic [NumBtn-1:0] press;

  assign btn_raw = {i_btn_clr, i_btn_load, i_btn_sign};

  always_ff @(posedge sys_clk) begin
    if (!i_rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_dly_q <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      db_dly_q <= db;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  for (genvar g = 0; g < NumBtn; g++) begin : g_debounce
    logic [CntW-1:0] cnt_q;
    logic            db_q;

    // Any cycle where s2 agrees with db restarts the count, so short glitches never land.
    always_ff @(posedge sys_clk) begin
      if (!i_rst_n) begin
        cnt_q <= '0;
        db_q  <= 1'b0;
      end else if (sync2_q[g] == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        db_q  <= sync2_q[g];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end

    assign db[g] = db_q;
  end
`else
  assign db = sync2_q;
`endif

  assign press = db & ~db_dly_q;

  // --------------------------------------------------------------------------
  // Entry FSM and operand registers
  // --------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [4:0] a_q, a_d;
  logic [4:0] b_q, b_d;
  logic       sign_q, sign_d;
  logic       valid_q, valid_d;
  logic       pulse_q, pulse_d;

  always_ff @(posedge sys_clk) begin
    if (!i_rst_n) begin
      state_q <= StEnterA;
      a_q     <= PosZero;
      b_q     <= PosZero;
      sign_q  <= 1'b1;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
    end
  end

  // Priority clr > load > sign; a load in the same cycle as sign takes the pre-toggle sign.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    valid_d = valid_q;
    pulse_d = 1'b0;

    if (press[BtnClr]) begin
      state_d = StEnterA;
      valid_d = 1'b0;
      sign_d  = 1'b1;
    end else begin
      case (state_q)
        StEnterA: begin
          if (press[BtnLoad]) begin
            a_d     = {sign_q, i_sw};
            sign_d  = 1'b1;
            state_d = StEnterB;
            pulse_d = 1'b1;
          end else if (press[BtnSign]) begin
            sign_d = ~sign_q;
          end
        end
        StEnterB: begin
          if (press[BtnLoad]) begin
            b_d     = {sign_q, i_sw};
            sign_d  = 1'b1;
            state_d = StReady;
            valid_d = 1'b1;
            pulse_d = 1'b1;
          end else if (press[BtnSign]) begin
            sign_d = ~sign_q;
          end
        end
        StReady: begin
          // A load here starts a fresh entry rather than committing anything.
          if (press[BtnLoad]) begin
            state_d = StEnterA;
            valid_d = 1'b0;
            sign_d  = 1'b1;
          end
        end
        default: begin
          state_d = StEnterA;
          valid_d = 1'b0;
          sign_d  = 1'b1;
        end
      endcase
    end
  end

  assign o_A          = a_q;
  assign o_B          = b_q;
  assign o_stage_sign = sign_q;
  assign o_state      = state_q;
  assign o_valid      = valid_q;
  assign o_load_pulse = pulse_q;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with DEBOUNCE_CYCLES = 4; expectations adapt to whether
// DEBOUNCE_EN is defined.
`timescale 1ns/1ps

module tb_operand_entry;

  localparam int unsigned Dc = 4;
`ifdef DEBOUNCE_EN
  localparam int Lat = Dc + 3;  // edges from first sampling of a rise to the visible update
`else
  localparam int Lat = 3;
`endif

  logic       sys_clk;
  logic       i_rst_n;
  logic [3:0] i_sw;
  logic       i_btn_sign;
  logic       i_btn_load;
  logic       i_btn_clr;
  logic [4:0] o_A;
  logic [4:0] o_B;
  logic       o_stage_sign;
  logic [1:0] o_state;
  logic       o_valid;
  logic       o_load_pulse;

  int total;
  int bad;
  int pulses;

  operand_entry #(
    .DEBOUNCE_CYCLES(Dc)
  ) dut (
    .sys_clk     (sys_clk),
    .i_rst_n     (i_rst_n),
    .i_sw        (i_sw),
    .i_btn_sign  (i_btn_sign),
    .i_btn_load  (i_btn_load),
    .i_btn_clr   (i_btn_clr),
    .o_A         (o_A),
    .o_B         (o_B),
    .o_stage_sign(o_stage_sign),
    .o_state     (o_state),
    .o_valid     (o_valid),
    .o_load_pulse(o_load_pulse)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (o_load_pulse === 1'b1) pulses++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic s, input logic l, input logic c, input int hold);
    i_btn_sign = s;
    i_btn_load = l;
    i_btn_clr  = c;
    ticks(hold);
    i_btn_sign = 1'b0;
    i_btn_load = 1'b0;
    i_btn_clr  = 1'b0;
    ticks(Lat + 2);
  endtask

  task automatic test_reset();
    i_rst_n    = 1'b0;
    i_sw       = 4'h0;
    i_btn_sign = 1'b0;
    i_btn_load = 1'b0;
    i_btn_clr  = 1'b0;
    ticks(2);
    i_rst_n = 1'b1;
    tick();
    total++; if (o_A !== 5'h10) begin bad++; $display("FAIL reset_a: got %h want 10", o_A); end
    total++; if (o_B !== 5'h10) begin bad++; $display("FAIL reset_b: got %h want 10", o_B); end
    total++; if (o_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", o_state); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    total++; if (o_stage_sign !== 1'b1) begin bad++; $display("FAIL reset_sign: got %b want 1", o_stage_sign); end
    total++; if (o_load_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b want 0", o_load_pulse); end
  endtask

  task automatic test_load_sign();
    pulses = 0;
    i_sw = 4'h7;
    i_btn_load = 1'b1;
    ticks(Lat - 1);
    total++; if (o_state !== 2'd0) begin bad++; $display("FAIL load_early: state got %0d want 0", o_state); end
    tick();
    total++; if (o_A !== 5'h17) begin bad++; $display("FAIL load_a: got %h want 17", o_A); end
    total++; if (o_state !== 2'd1) begin bad++; $display("FAIL load_a_state: got %0d want 1", o_state); end
    total++; if (o_load_pulse !== 1'b1) begin bad++; $display("FAIL load_a_pulse: got %b want 1", o_load_pulse); end
    ticks(10 - Lat);
    i_btn_load = 1'b0;
    ticks(Lat + 2);
    total++; if (pulses !== 1) begin bad++; $display("FAIL hold_one_pulse: got %0d want 1", pulses); end
    total++; if (o_state !== 2'd1) begin bad++; $display("FAIL hold_state: got %0d want 1", o_state); end
    i_sw = 4'h3;
    press(1'b1, 1'b0, 1'b0, Lat + 1);
    total++; if (o_stage_sign !== 1'b0) begin bad++; $display("FAIL sign_toggle: got %b want 0", o_stage_sign); end
    press(1'b0, 1'b1, 1'b0, Lat + 1);
    total++; if (o_B !== 5'h03) begin bad++; $display("FAIL load_b: got %h want 03", o_B); end
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL load_b_valid: got %b want 1", o_valid); end
    total++; if (o_state !== 2'd2) begin bad++; $display("FAIL load_b_state: got %0d want 2", o_state); end
    total++; if (o_stage_sign !== 1'b1) begin bad++; $display("FAIL load_b_sign: got %b want 1", o_stage_sign); end
    total++; if (o_A !== 5'h17) begin bad++; $display("FAIL a_kept: got %h want 17", o_A); end
  endtask

  task automatic test_glitch();
    logic [4:0] exp_a;
    int         exp_pulses;
`ifdef DEBOUNCE_EN
    exp_a      = 5'h17;
    exp_pulses = 0;
`else
    // Undebounced: READY->A (no pulse), commit A, commit B, all with i_sw = 3.
    exp_a      = 5'h13;
    exp_pulses = 2;
`endif
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      i_btn_load = 1'b1;
      ticks(3);
      i_btn_load = 1'b0;
      ticks(3);
    end
    ticks(Lat + 2);
    total++; if (pulses !== exp_pulses) begin bad++; $display("FAIL glitch_pulses: got %0d want %0d", pulses, exp_pulses); end
    total++; if (o_state !== 2'd2) begin bad++; $display("FAIL glitch_state: got %0d want 2", o_state); end
    total++; if (o_A !== exp_a) begin bad++; $display("FAIL glitch_a: got %h want %h", o_A, exp_a); end
  endtask

  task automatic test_simultaneous();
    press(1'b0, 1'b0, 1'b1, Lat + 1);
    total++; if (o_state !== 2'd0) begin bad++; $display("FAIL simul_pre_state: got %0d want 0", o_state); end
    pulses = 0;
    i_sw = 4'h9;
    press(1'b1, 1'b1, 1'b0, Lat + 1);
    total++; if (o_A !== 5'h19) begin bad++; $display("FAIL simul_a: got %h want 19", o_A); end
    total++; if (o_stage_sign !== 1'b1) begin bad++; $display("FAIL simul_sign: got %b want 1", o_stage_sign); end
    total++; if (o_state !== 2'd1) begin bad++; $display("FAIL simul_state: got %0d want 1", o_state); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL simul_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_ready_clr();
    i_sw = 4'h5;
    press(1'b1, 1'b0, 1'b0, Lat + 1);
    press(1'b0, 1'b1, 1'b0, Lat + 1);
    total++; if (o_B !== 5'h05) begin bad++; $display("FAIL neg_b: got %h want 05", o_B); end
    total++; if (o_state !== 2'd2) begin bad++; $display("FAIL ready_state: got %0d want 2", o_state); end
    press(1'b0, 1'b0, 1'b1, Lat + 1);
    total++; if (o_state !== 2'd0) begin bad++; $display("FAIL clr_state: got %0d want 0", o_state); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL clr_valid: got %b want 0", o_valid); end
    total++; if (o_A !== 5'h19) begin bad++; $display("FAIL clr_a_kept: got %h want 19", o_A); end
    total++; if (o_B !== 5'h05) begin bad++; $display("FAIL clr_b_kept: got %h want 05", o_B); end
    i_sw = 4'h2;
    press(1'b0, 1'b1, 1'b0, Lat + 1);
    i_sw = 4'h6;
    press(1'b0, 1'b1, 1'b0, Lat + 1);
    total++; if (o_state !== 2'd2) begin bad++; $display("FAIL ready2_state: got %0d want 2", o_state); end
    pulses = 0;
    i_sw = 4'hf;
    press(1'b0, 1'b1, 1'b0, Lat + 1);
    total++; if (o_state !== 2'd0) begin bad++; $display("FAIL ready_load_state: got %0d want 0", o_state); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL ready_load_pulse: got %0d want 0", pulses); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL ready_load_valid: got %b want 0", o_valid); end
    total++; if (o_A !== 5'h12) begin bad++; $display("FAIL ready_load_a: got %h want 12", o_A); end
    total++; if (o_B !== 5'h16) begin bad++; $display("FAIL ready_load_b: got %h want 16", o_B); end
  endtask

  task automatic test_reset_mid();
    i_sw = 4'h1;
    press(1'b0, 1'b1, 1'b0, Lat + 1);
    total++; if (o_state !== 2'd1) begin bad++; $display("FAIL mid_pre_state: got %0d want 1", o_state); end
    i_sw = 4'ha;
    i_btn_load = 1'b1;
    ticks(Lat - 3);  // debounce counter sits at 2 here
    i_rst_n = 1'b0;
    tick();
    total++; if (o_state !== 2'd0) begin bad++; $display("FAIL mid_rst_state: got %0d want 0", o_state); end
    total++; if (o_A !== 5'h10) begin bad++; $display("FAIL mid_rst_a: got %h want 10", o_A); end
    total++; if (o_B !== 5'h10) begin bad++; $display("FAIL mid_rst_b: got %h want 10", o_B); end
    total++; if (o_stage_sign !== 1'b1) begin bad++; $display("FAIL mid_rst_sign: got %b want 1", o_stage_sign); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", o_valid); end
    i_rst_n = 1'b1;
    ticks(Lat - 1);
    total++; if (o_state !== 2'd0) begin bad++; $display("FAIL mid_early: state got %0d want 0", o_state); end
    tick();
    total++; if (o_state !== 2'd1) begin bad++; $display("FAIL mid_late_state: got %0d want 1", o_state); end
    total++; if (o_A !== 5'h1a) begin bad++; $display("FAIL mid_late_a: got %h want 1a", o_A); end
    i_btn_load = 1'b0;
    ticks(Lat + 2);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    pulses = 0;
    test_reset();
    test_load_sign();
    test_glitch();
    test_simultaneous();
    test_ready_clr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
